mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Load/store front end placed directly upstream of the word-wide RAM (instruction/data memory).
// - Converts core byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word accesses.
// - Sub-word stores are done by an internal read-modify-write sequence.
// - Loads are returned lane-aligned and sign- or zero-extended.
// PARAMETERS
// - ADDR_W, 12: RAM word-address width. Word index = req_addr[ADDR_W+1:2].
// - DATA_W, 32: RAM/core data width. Fixed at 32; other values are unsupported.
// PORTS
// - clk           in   1   Rising-edge clock; the RAM shares this clock.
// - rst           in   1   Asynchronous, active-high reset.
// - req_valid     in   1   Core request valid.
// - req_ready     out  1   High only in IDLE. Accept = req_valid & req_ready at a clk edge.
// - req_we        in   1   1 = store, 0 = load.
// - req_size      in   2   00 byte, 01 half, 10 word, 11 illegal.
// - req_unsigned  in   1   Load zero-extends when 1. Ignored for stores.
// - req_addr      in   32  Byte address.
// - req_wdata     in   32  Store data, right-justified.
// - resp_valid    out  1   One-cycle completion pulse. No back-pressure.
// - resp_err      out  1   Valid with resp_valid. Flags misaligned, out-of-range or illegal size.
// - resp_rdata    out  32  Load result, valid with resp_valid. 0 for stores and errors.
// - ram_r_wn      out  1   To RAM r_wn. 1 = read, 0 = write.
// - ram_address   out  12  To RAM address (word index).
// - ram_data_in   out  32  To RAM data_in.
// - ram_data_out  in   32  From RAM data_out. Valid the cycle after the RAM samples a read address.
// BEHAVIOUR
// - Outputs: all registered.
// - Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_r_wn=1, ram_address=0, ram_data_in=0, state=IDLE.
// - Write strobe: the RAM writes on every edge where r_wn=0.
//   - ram_r_wn is 0 only in state WR, and for exactly one cycle per store.
// - FSM states: IDLE, RD_ADDR, RD_DATA, WR, DONE.
//   - IDLE, accept of an error request -> DONE with err=1. No RAM access.
//   - IDLE, accept of a load -> RD_ADDR. ram_address latched.
//   - IDLE, accept of SW -> WR. ram_data_in = req_wdata.
//   - IDLE, accept of SB/SH -> RD_ADDR with an rmw flag set.
//   - RD_ADDR -> RD_DATA. The RAM samples the address on this edge.
//   - RD_DATA, load -> DONE. resp_rdata = extracted and extended ram_data_out.
//   - RD_DATA, rmw -> WR. ram_data_in = ram_data_out with the addressed lane(s) replaced.
//   - WR -> DONE. The RAM writes on this edge.
//   - DONE -> IDLE. resp_valid is high during DONE.
// - Latency, counted as edges from accept to resp_valid high:
//   - error: 1
//   - SW: 2
//   - load: 3
//   - SB/SH: 4
// - Lane rules: little-endian.
//   - Byte lane = addr[1:0].
//   - Half lane = addr[1]; a half access requires addr[0]=0.
//   - A word access requires addr[1:0]=0.
//   - Sign-extend from bit 7 or bit 15 unless req_unsigned.
//   - Store merge replaces only the addressed bytes. Other bytes keep their RAM value.
// - Errors:
//   - misaligned access;
//   - req_addr[31:ADDR_W+2] nonzero;
//   - req_size=11.
//   - On error: no RAM write occurs and resp_rdata=0.
// - Back-to-back requests: req_ready rises in the IDLE cycle after DONE. There are no overlapped requests.
// - Bus hold: ram_address and ram_data_in hold their last values in IDLE. ram_r_wn stays 1.
// - Reset mid-operation: rst immediately forces ram_r_wn=1 and state IDLE.
//   - A WR that has not reached its edge is aborted; RAM contents are unchanged.
//   - No resp_valid is issued for the aborted request.
// - Inputs after accept: request inputs are don't-care. All request fields are latched at accept.
// STRUCTURE
// - Package mem_pkg:
//   - size codes SZ_B/SZ_H/SZ_W;
//   - state enum constants;
//   - the misalign check as a function.
// - Sub-module mem_lane_align (combinational), two functions:
//   - extract(word, lane, size, unsigned) -> 32-bit load value;
//   - merge(word, wdata, lane, size) -> 32-bit store word.
// - Top level: FSM plus request/response registers.
// TESTING
// - Bench: pair the unit with the existing RAM model.
// - SW 0x0000_0010 <- 0xDEADBEEF, then LW 0x10:
//   - response 0xDEADBEEF, err=0;
//   - SW resp 2 edges after accept, LW resp 3 edges after accept.
// - SB 0x13 <- 0x000000A5 over 0x11223344, then LW 0x10:
//   - result 0xA5223344;
//   - r_wn low exactly 1 cycle;
//   - resp 4 edges after accept.
// - Load extension, word = 0x80FF7F01:
//   - LB 0x12 -> 0xFFFFFFFF;
//   - LBU 0x12 -> 0x000000FF;
//   - LH 0x12 -> 0xFFFF80FF;
//   - LHU 0x10 -> 0x00007F01.
// - Error requests: SH 0x11, LW 0x12, LW 0x0000_4000, size=11.
//   - Each gives resp_err=1 and rdata=0 one edge after accept.
//   - r_wn never goes low; the following LW shows memory unchanged.
// - Assert rst during WR of an SW 0x20 <- 0x12345678:
//   - ram_r_wn=1 immediately, req_ready=1, no resp_valid;
//   - LW 0x20 returns the old value.
// - Hold req_valid high for 8 back-to-back LW requests:
//   - one accept per completed response;
//   - req_ready=0 in RD_ADDR/RD_DATA/DONE;
//   - no request is dropped or duplicated.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end.
//   - SZ_B/SZ_H/SZ_W : request size codes (2'b11 is an illegal size)
//   - state_e        : access sequencer states
//   - misaligned()   : alignment check for a size code and byte lane
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Bytes never misalign; halves need an even address; words need addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_H:    misaligned = lane[0];
      SZ_W:    misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering.
//   word_i  : current RAM word
//   wdata_i : right-justified store data
//   lane_i  : byte lane (address bits [1:0])
//   size_i  : SZ_B / SZ_H / SZ_W
//   uns_i   : zero-extend loads when 1
//   load_o  : lane-aligned, extended load value
//   merge_o : word_i with only the addressed byte(s) replaced by wdata_i
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    extract = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    extract = {{16{~uns & sh[15]}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_B:    mask = 32'h0000_00FF;
      SZ_H:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask  = mask << {lane, 3'b000};
    data  = wdata << {lane, 3'b000};
    merge = (word & ~mask) | (data & mask);
  endfunction

  assign load_o  = extract(word_i, lane_i, size_i, uns_i);
  assign merge_o = merge(word_i, wdata_i, lane_i, size_i);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a synchronous word-wide RAM.
// Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word
// accesses; sub-word stores run a read-modify-write. All outputs registered.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake; a request is accepted on a clk
//                            edge where both are high. req_ready is high only in
//                            IDLE, so exactly one request is in flight. All
//                            request fields are latched at accept.
//   req_we/size/unsigned     store flag, size code, load zero-extend
//   req_addr/req_wdata       byte address, right-justified store data
//   resp_valid/err/rdata     one-cycle completion pulse (no back-pressure)
//   ram_r_wn/address/data_in RAM control (RAM writes on every edge r_wn=0)
//   ram_data_out             RAM read data, valid the cycle after the address
//   dbg_state_o              current sequencer state (state_e encoding)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [2:0]        dbg_state_o
);

  state_e              state_q, state_d;
  logic                rmw_q, rmw_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          lane_q, lane_d;
  logic                uns_q, uns_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                r_wn_q, r_wn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   merge_val;
  logic                req_bad;

  // Illegal size, misaligned lane, or address bits beyond the RAM.
  assign req_bad = (req_size == 2'b11) || misaligned(req_size, req_addr[1:0]) ||
                   (|req_addr[31:ADDR_W+2]);

  mem_lane_align u_align (
    .word_i  (ram_data_out),
    .wdata_i (wdata_q),
    .lane_i  (lane_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .load_o  (load_val),
    .merge_o (merge_val)
  );

  always_comb begin
    state_d      = state_q;
    rmw_d        = rmw_q;
    size_d       = size_q;
    lane_d       = lane_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    r_wn_d       = 1'b1;
    addr_d       = addr_q;   // bus holds its last value outside accesses
    din_d        = din_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          size_d  = req_size;
          lane_d  = req_addr[1:0];
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rmw_d   = req_we;  // only consulted on the read path (SB/SH)
          if (req_bad) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            addr_d = req_addr[ADDR_W+1:2];
            if (req_we && req_size == SZ_W) begin
              state_d = WR;
              r_wn_d  = 1'b0;
              din_d   = req_wdata;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
      end
      RD_ADDR: state_d = RD_DATA;  // RAM samples the address on this edge
      RD_DATA: begin
        if (rmw_q) begin
          state_d = WR;
          r_wn_d  = 1'b0;
          din_d   = merge_val;
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_val;
        end
      end
      WR: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rmw_q        <= 1'b0;
      size_q       <= SZ_W;
      lane_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      r_wn_q       <= 1'b1;
      addr_q       <= '0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      rmw_q        <= rmw_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      r_wn_q       <= r_wn_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
    end
  end

  assign req_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign ram_r_wn    = r_wn_q;
  assign ram_address = addr_q;
  assign ram_data_in = din_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_r_wn;
  logic [11:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_r_wn     (ram_r_wn),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- RAM model: synchronous read, write when r_wn=0 ----------------
  logic [31:0] ram_mem [0:4095];
  always @(posedge clk) begin
    if (!ram_r_wn) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  // ---------------- event monitors ----------------
  int wr_cnt = 0;
  int resp_cnt = 0;
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (!ram_r_wn) wr_cnt <= wr_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] mm [int];  // word index -> word

  function automatic logic m_err(input int size, input logic [31:0] addr);
    return (size == 3) || (addr >= 32'h4000) || (size == 1 && addr % 2 != 0) ||
           (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int lane, input int size,
                                         input logic uns);
    int v;
    if (size == 2) return w;
    if (size == 0) begin
      v = int'((w >> (8 * lane)) & 32'hFF);
      if (!uns && v >= 128) v -= 256;
    end else begin
      v = int'((w >> (8 * lane)) & 32'hFFFF);
      if (!uns && v >= 32768) v -= 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                          input int lane, input int size);
    int n;
    n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    for (int i = 0; i < n; i++) w[8 * (lane + i) +: 8] = wd[8 * i +: 8];
    return w;
  endfunction

  function automatic int m_lat(input logic we, input int size, input logic [31:0] addr);
    if (m_err(size, addr)) return 1;
    if (!we) return 3;
    return (size == 2) ? 2 : 4;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, returns response fields, accept-to-resp latency in
  // edges (99 when a bound expires) and number of RAM write cycles.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int wr_d);
    int n;
    int w0;
    rdata = '0; err = 1'b0; lat = 99; wr_d = 0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) return;
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    // fields are don't-care after accept
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; break; end
      @(negedge clk);
    end
    wr_d = wr_cnt - w0;
  endtask

  // model-updating wrapper used to initialise memory
  task automatic preload(input logic [31:0] addr, input logic [31:0] value);
    logic [31:0] rd; logic er; int lt; int wd;
    do_req(1'b1, 2'b10, 1'b0, addr, value, rd, er, lt, wd);
    mm[int'(addr[13:2])] = value;
    n_cmp++;
    if (er !== 1'b0 || lt != 2 || wd != 1) begin
      n_fail++;
      $display("FAIL preload_%h: err=%b lat=%0d writes=%0d, required err=0 lat=2 writes=1", addr, er, lt, wd);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 8;
    if (req_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    if (resp_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    if (resp_err !== 1'b0)    begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    if (ram_r_wn !== 1'b1)    begin n_fail++; $display("FAIL rst_r_wn: got %b want 1", ram_r_wn); end
    if (ram_address !== 12'h0) begin n_fail++; $display("FAIL rst_address: got %h want 0", ram_address); end
    if (ram_data_in !== 32'h0) begin n_fail++; $display("FAIL rst_data_in: got %h want 0", ram_data_in); end
    if (dbg_state !== 3'd0)   begin n_fail++; $display("FAIL rst_state: got %0d want 0 (IDLE)", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle: ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lt; int wd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt, wd);
    mm[4] = 32'hDEADBEEF;
    n_cmp += 4;
    if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
    if (lt != 2)     begin n_fail++; $display("FAIL sw_lat: got %0d want 2", lt); end
    if (wd != 1)     begin n_fail++; $display("FAIL sw_writes: got %0d want 1", wd); end
    if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, wd);
    n_cmp += 4;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", er); end
    if (lt != 3)     begin n_fail++; $display("FAIL lw_lat: got %0d want 3", lt); end
    if (wd != 0)     begin n_fail++; $display("FAIL lw_writes: got %0d want 0", wd); end
    // bus hold in IDLE after the load
    @(negedge clk); @(negedge clk);
    n_cmp += 2;
    if (ram_address !== 12'h004) begin n_fail++; $display("FAIL hold_address: got %h want 004", ram_address); end
    if (ram_data_in !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_data_in: got %h want deadbeef", ram_data_in); end
  endtask

  task automatic test_sub_word_store();
    logic [31:0] rd; logic er; int lt; int wd;
    preload(32'h10, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, rd, er, lt, wd);
    n_cmp += 3;
    if (lt != 4)     begin n_fail++; $display("FAIL sb_lat: got %0d want 4", lt); end
    if (wd != 1)     begin n_fail++; $display("FAIL sb_write_cycles: got %0d want 1", wd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, wd);
    n_cmp++;
    if (rd !== 32'hA5223344) begin n_fail++; $display("FAIL sb_merge: got %h want a5223344", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h5555BEEF, rd, er, lt, wd);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, wd);
    mm[4] = 32'hA522BEEF;
    n_cmp++;
    if (rd !== 32'hA522BEEF) begin n_fail++; $display("FAIL sh_merge: got %h want a522beef", rd); end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic er; int lt; int wd;
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h12, 32'h12, 32'h12, 32'h10};
    logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
    preload(32'h10, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lt, wd);
      n_cmp += 2;
      if (rd !== ex[i]) begin n_fail++; $display("FAIL ext_%0d: got %h want %h", i, rd, ex[i]); end
      if (lt != 3 || er !== 1'b0) begin n_fail++; $display("FAIL ext_%0d_resp: lat=%0d err=%b want 3/0", i, lt, er); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lt; int wd;
    logic        we [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [6] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] ad [6] = '{32'h11, 32'h12, 32'h4000, 32'h10, 32'h10, 32'h4010};
    preload(32'h10, 32'h0BADC0DE);
    for (int i = 0; i < 6; i++) begin
      do_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, rd, er, lt, wd);
      n_cmp += 4;
      if (er !== 1'b1)  begin n_fail++; $display("FAIL err_%0d_flag: got %b want 1", i, er); end
      if (rd !== 32'h0) begin n_fail++; $display("FAIL err_%0d_rdata: got %h want 0", i, rd); end
      if (lt != 1)      begin n_fail++; $display("FAIL err_%0d_lat: got %0d want 1", i, lt); end
      if (wd != 0)      begin n_fail++; $display("FAIL err_%0d_writes: got %0d want 0", i, wd); end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, wd);
    n_cmp++;
    if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL err_mem_unchanged: got %h want 0badc0de", rd); end
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] rd; logic er; int lt; int wd;
    int r0; int w0; int n;
    preload(32'h20, 32'hCAFEF00D);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    r0 = resp_cnt; w0 = wr_cnt;
    n_cmp++;
    if (ram_r_wn !== 1'b0) begin n_fail++; $display("FAIL midwr_in_wr: r_wn=%b want 0 before reset", ram_r_wn); end
    rst = 1'b1;
    #1;
    n_cmp += 3;
    if (ram_r_wn !== 1'b1)  begin n_fail++; $display("FAIL midwr_r_wn: got %b want 1", ram_r_wn); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midwr_ready: got %b want 1", req_ready); end
    if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL midwr_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp += 2;
    if (resp_cnt != r0) begin n_fail++; $display("FAIL midwr_no_resp: responses %0d want 0", resp_cnt - r0); end
    if (wr_cnt != w0)   begin n_fail++; $display("FAIL midwr_no_write: writes %0d want 0", wr_cnt - w0); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lt, wd);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midwr_old_value: got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    int a0; int r0; int n; int bad_ready;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    for (int i = 0; i < 8; i++) preload(32'h40 + 32'(4 * i), $urandom);
    for (int i = 0; i < 8; i++) exp_q.push_back(mm[16 + i]);
    @(negedge clk);
    a0 = acc_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_addr = 32'h40 + 32'(4 * i);
      @(posedge clk);
      @(negedge clk);
      bad_ready = 0;
      n = 0;
      while (n < 20) begin
        if (req_ready !== 1'b0) bad_ready++;
        if (resp_valid) break;
        @(negedge clk); n++;
      end
      got = resp_rdata;
      if (i == 7) req_valid = 1'b0;
      n_cmp += 2;
      if (n >= 20 || got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i, got, exp_q[0]); end
      if (bad_ready != 0) begin n_fail++; $display("FAIL b2b_ready_%0d: ready high in %0d busy cycles, want 0", i, bad_ready); end
      void'(exp_q.pop_front());
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (acc_cnt - a0 != 8)  begin n_fail++; $display("FAIL b2b_accepts: got %0d want 8", acc_cnt - a0); end
    if (resp_cnt - r0 != 8) begin n_fail++; $display("FAIL b2b_responses: got %0d want 8", resp_cnt - r0); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lt; int wd;
    logic we; logic uns; int size; logic [31:0] addr; logic [31:0] wdata;
    logic e_err; logic [31:0] e_rd; int idx;
    for (int i = 0; i < 8; i++) preload(32'h100 + 32'(4 * i), $urandom);
    for (int t = 0; t < 40; t++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      addr  = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h4000;
      wdata = $urandom;
      do_req(we, 2'(size), uns, addr, wdata, rd, er, lt, wd);
      e_err = m_err(size, addr);
      idx   = int'(addr[13:2]);
      e_rd  = (e_err || we) ? 32'h0 : m_load(mm[idx], int'(addr[1:0]), size, uns);
      if (!e_err && we) mm[idx] = m_merge(mm[idx], wdata, int'(addr[1:0]), size);
      n_cmp += 4;
      if (er !== e_err) begin n_fail++; $display("FAIL rnd_%0d_err: got %b want %b (addr %h size %0d)", t, er, e_err, addr, size); end
      if (rd !== e_rd)  begin n_fail++; $display("FAIL rnd_%0d_rdata: got %h want %h (addr %h size %0d)", t, rd, e_rd, addr, size); end
      if (lt != m_lat(we, size, addr)) begin n_fail++; $display("FAIL rnd_%0d_lat: got %0d want %0d", t, lt, m_lat(we, size, addr)); end
      if (wd != ((!e_err && we) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_%0d_writes: got %0d want %0d", t, wd, (!e_err && we) ? 1 : 0); end
    end
    // read back the whole region against the model
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 2'b10, 1'b0, 32'h100 + 32'(4 * i), 32'h0, rd, er, lt, wd);
      n_cmp++;
      if (rd !== mm[64 + i]) begin n_fail++; $display("FAIL rnd_final_%0d: got %h want %h", i, rd, mm[64 + i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_sub_word_store();
    test_load_ext();
    test_errors();
    test_reset_mid_wr();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
